// File: rtl/strength_log_pkg.sv
// strength_log_pkg: shared encodings, constants and FSM state for the strength change logger.
// Macro STRENGTH_CHANGE_LOG_EN selects the comparison mask: defined compares the full
// 8-bit code, undefined compares only the value field [7:6].
package strength_log_pkg;
    localparam int CODE_W  = 8;
    localparam int VAL_LSB = 6;
    localparam int S0_LSB  = 3;
    localparam int S1_LSB  = 0;
    localparam logic [1:0] V_0 = 2'b00;
    localparam logic [1:0] V_1 = 2'b01;
    localparam logic [1:0] V_Z = 2'b10;
    localparam logic [1:0] V_X = 2'b11;
    localparam logic [CODE_W-1:0] SHADOW_RST = {V_Z, 3'd0, 3'd0};
`ifdef STRENGTH_CHANGE_LOG_EN
    localparam logic [CODE_W-1:0] CMP_MASK = 8'hFF;
`else
    localparam logic [CODE_W-1:0] CMP_MASK = 8'hC0;
`endif
    typedef enum logic {IDLE, SCAN} state_e;
endpackage

// File: rtl/strength_change_logger_if.sv
// strength_change_logger_if: sample strobe and record-drain signals of the change logger.
// Ports: net_in/sample_en/rec_ready driven by master; sample_rdy, rec_valid, rec_idx,
// rec_val, rec_ts, fifo_count driven by slave (the logger).
interface strength_change_logger_if #(
    parameter int NUM_NETS = 8,
    parameter int TS_W     = 16,
    parameter int DEPTH    = 16
);
    logic [NUM_NETS*8-1:0]       net_in;
    logic                        sample_en;
    logic                        sample_rdy;
    logic                        rec_valid;
    logic                        rec_ready;
    logic [$clog2(NUM_NETS)-1:0] rec_idx;
    logic [7:0]                  rec_val;
    logic [TS_W-1:0]             rec_ts;
    logic [$clog2(DEPTH):0]      fifo_count;
    modport master (output net_in, sample_en, rec_ready,
                    input  sample_rdy, rec_valid, rec_idx, rec_val, rec_ts, fifo_count);
    modport slave  (input  net_in, sample_en, rec_ready,
                    output sample_rdy, rec_valid, rec_idx, rec_val, rec_ts, fifo_count);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO, W bits wide, DEPTH (power of 2) entries.
// Ports: clk, rst_n (async low); push/din write; pop consumes head; dout shows head
// (zero when empty); full, empty, count status.
module sync_fifo_fwft #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        // a pop in the same cycle frees the slot, so a push into a full FIFO is legal
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout    = empty ? '0 : mem_q[rd_q];
        count   = cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/strength_change_logger.sv
// strength_change_logger: logs per-net value/strength changes as time-stamped FIFO records.
// Ports: clk, rst_n (async low); bus (slave modport): net_in codes, sample_en/sample_rdy
// strobe, rec_valid/rec_ready/rec_idx/rec_val/rec_ts record drain, fifo_count.
// Macro STRENGTH_CHANGE_LOG_EN: defined logs strength-only changes too; undefined
// compares only the value field.
module strength_change_logger
    import strength_log_pkg::*;
#(
    parameter int NUM_NETS = 8,
    parameter int TS_W     = 16,
    parameter int DEPTH    = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    strength_change_logger_if.slave bus
);
    localparam int IW = $clog2(NUM_NETS);
    localparam int RW = IW + CODE_W + TS_W;
    state_e                state_q, state_d;
    logic [NUM_NETS-1:0]   pending_q, pending_d, changed;
    logic [CODE_W-1:0]     shadow_q [NUM_NETS];
    logic [CODE_W-1:0]     shadow_d [NUM_NETS];
    logic [TS_W-1:0]       ts_q, ts_d, ts_latch_q, ts_latch_d;
    logic [IW-1:0]         pick;
    logic                  push, full, empty;
    logic [RW-1:0]         head;
    always_comb begin
        pick = '0;
        // descending scan so the lowest pending index wins
        for (int i = NUM_NETS - 1; i >= 0; i--) if (pending_q[i]) pick = IW'(i);
        for (int i = 0; i < NUM_NETS; i++)
            changed[i] = ((bus.net_in[CODE_W*i +: CODE_W] ^ shadow_q[i]) & CMP_MASK) != '0;
    end
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        ts_d       = ts_q + 1'b1;
        ts_latch_d = ts_latch_q;
        push       = 1'b0;
        if (state_q == IDLE) begin
            if (bus.sample_en) begin
                pending_d  = changed;
                ts_latch_d = ts_q;
                state_d    = |changed ? SCAN : IDLE;
                for (int i = 0; i < NUM_NETS; i++)
                    shadow_d[i] = changed[i] ? bus.net_in[CODE_W*i +: CODE_W] : shadow_q[i];
            end
        end else if (!full || bus.rec_ready) begin
            push            = 1'b1;
            pending_d[pick] = 1'b0;
            state_d         = pending_d == '0 ? IDLE : SCAN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            ts_q       <= '0;
            ts_latch_q <= '0;
            for (int i = 0; i < NUM_NETS; i++) shadow_q[i] <= SHADOW_RST;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ts_q       <= ts_d;
            ts_latch_q <= ts_latch_d;
            shadow_q   <= shadow_d;
        end
    end
    sync_fifo_fwft #(.W(RW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({pick, shadow_q[pick], ts_latch_q}),
        .pop   (bus.rec_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.fifo_count)
    );
    assign bus.sample_rdy = state_q == IDLE;
    assign bus.rec_valid  = !empty;
    assign {bus.rec_idx, bus.rec_val, bus.rec_ts} = head;
endmodule

// File: tb/tb_strength_change_logger.sv
// tb_strength_change_logger: directed self-checking bench for strength_change_logger.
module tb_strength_change_logger;
    localparam int N  = 8;
    localparam int TW = 8;
    localparam int D  = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    strength_change_logger_if #(.NUM_NETS(N), .TS_W(TW), .DEPTH(D)) bus ();
    strength_change_logger #(.NUM_NETS(N), .TS_W(TW), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    // reference timestamp: counts edges since reset release, independent of the DUT
    logic [TW-1:0] tb_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else tb_ts <= tb_ts + 1'b1;
    end
    int checks = 0;
    int failures = 0;
    logic [7:0] nets [N];
    logic [TW-1:0] t1, tx, t3a, t3b, ta, tbb, tc, td, te, tw;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic drive_nets();
        for (int i = 0; i < N; i++) bus.net_in[8*i +: 8] = nets[i];
    endtask
    task automatic strobe(output logic [TW-1:0] ts);
        drive_nets();
        ts = tb_ts;
        bus.sample_en = 1'b1;
        tick(1);
        bus.sample_en = 1'b0;
    endtask
    task automatic head(input string tag, input int idx, input logic [7:0] val, input logic [TW-1:0] ts);
        chk({tag, "_valid"}, 32'(bus.rec_valid), 32'd1);
        chk({tag, "_idx"}, 32'(bus.rec_idx), 32'(idx));
        chk({tag, "_val"}, 32'(bus.rec_val), 32'(val));
        chk({tag, "_ts"}, 32'(bus.rec_ts), 32'(ts));
    endtask
    task automatic pop();
        bus.rec_ready = 1'b1;
        tick(1);
        bus.rec_ready = 1'b0;
    endtask
    task automatic reset_chk(input string tag);
        chk({tag, "_rdy"}, 32'(bus.sample_rdy), 32'd1);
        chk({tag, "_valid"}, 32'(bus.rec_valid), 32'd0);
        chk({tag, "_idx"}, 32'(bus.rec_idx), 32'd0);
        chk({tag, "_val"}, 32'(bus.rec_val), 32'd0);
        chk({tag, "_ts"}, 32'(bus.rec_ts), 32'd0);
        chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
    endtask
    initial begin
        bus.sample_en = 1'b0;
        bus.rec_ready = 1'b0;
        for (int i = 0; i < N; i++) nets[i] = 8'h80;
        drive_nets();
        #2 rst_n = 1'b0;
        #10;
        reset_chk("rst");
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        // two changed nets, logged in index order with a shared timestamp
        nets[0] = 8'h00;
        nets[1] = 8'h7F;
        strobe(t1);
        chk("t1_busy", 32'(bus.sample_rdy), 32'd0);
        chk("t1_cnt0", 32'(bus.fifo_count), 32'd0);
        tick(1);
        head("t1_r0", 0, 8'h00, t1);
        chk("t1_cnt1", 32'(bus.fifo_count), 32'd1);
        tick(1);
        chk("t1_cnt2", 32'(bus.fifo_count), 32'd2);
        chk("t1_rdy", 32'(bus.sample_rdy), 32'd1);
        pop();
        head("t1_r1", 1, 8'h7F, t1);
        pop();
        chk("t1_empty", 32'(bus.rec_valid), 32'd0);
        chk("t1_cnt_end", 32'(bus.fifo_count), 32'd0);
        // identical strobe logs nothing
        strobe(tx);
        chk("t2_rdy", 32'(bus.sample_rdy), 32'd1);
        tick(2);
        chk("t2_valid", 32'(bus.rec_valid), 32'd0);
        chk("t2_cnt", 32'(bus.fifo_count), 32'd0);
        // strength-only change on net3
        nets[3] = 8'h7F;
        strobe(t3a);
        tick(1);
        head("t3_a", 3, 8'h7F, t3a);
        pop();
        nets[3] = 8'h76;
        strobe(t3b);
        tick(1);
`ifdef STRENGTH_CHANGE_LOG_EN
        head("t3_b", 3, 8'h76, t3b);
        pop();
`else
        chk("t3_none", 32'(bus.rec_valid), 32'd0);
`endif
        chk("t3_cnt", 32'(bus.fifo_count), 32'd0);
        // fill the FIFO, then stall a third scan against it
        for (int i = 0; i < N; i++) nets[i] = 8'hC0 + 8'(i);
        strobe(ta);
        tick(8);
        chk("t4_cnt8", 32'(bus.fifo_count), 32'd8);
        for (int i = 0; i < N; i++) nets[i] = 8'(i * 8 + 7);
        strobe(tbb);
        tick(8);
        chk("t4_cnt16", 32'(bus.fifo_count), 32'd16);
        for (int i = 0; i < N; i++) nets[i] = 8'h40 + 8'(i);
        strobe(tc);
        tick(3);
        chk("t4_full_cnt", 32'(bus.fifo_count), 32'd16);
        chk("t4_full_rdy", 32'(bus.sample_rdy), 32'd0);
        head("t4_stall1", 0, 8'hC0, ta);
        tick(2);
        head("t4_stall2", 0, 8'hC0, ta);
        bus.rec_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            head($sformatf("t4_drain%0d", n), n % 8,
                 n < 8 ? 8'hC0 + 8'(n % 8) : n < 16 ? 8'((n % 8) * 8 + 7) : 8'h40 + 8'(n % 8),
                 n < 8 ? ta : n < 16 ? tbb : tc);
            tick(1);
        end
        bus.rec_ready = 1'b0;
        chk("t4_empty", 32'(bus.rec_valid), 32'd0);
        chk("t4_cnt_end", 32'(bus.fifo_count), 32'd0);
        chk("t4_rdy_end", 32'(bus.sample_rdy), 32'd1);
        // async reset in the middle of a scan
        for (int i = 0; i < N; i++) nets[i] = 8'(i);
        strobe(td);
        tick(2);
        chk("t5_pre_cnt", 32'(bus.fifo_count), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        reset_chk("t5_rst");
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < N; i++) nets[i] = 8'h80;
        nets[2] = 8'h41;
        nets[3] = 8'h81;
        nets[5] = 8'hC3;
        strobe(te);
        tick(3);
        head("t5_r2", 2, 8'h41, te);
        pop();
`ifdef STRENGTH_CHANGE_LOG_EN
        head("t5_r3", 3, 8'h81, te);
        pop();
`endif
        head("t5_r5", 5, 8'hC3, te);
        pop();
        chk("t5_empty", 32'(bus.rec_valid), 32'd0);
        // timestamp wrap
        for (int n = 0; n < 300 && tb_ts != 8'hFF; n++) tick(1);
        chk("t6_reach", 32'(tb_ts), 32'hFF);
        tick(1);
        nets[0] = 8'h40;
        strobe(tw);
        tick(1);
        head("t6_wrap", 0, 8'h40, 8'h00);
        pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
